long_fifo_4bit_rd_packer: RTL

Read-side companion to the chained 4-bit long BRAM FIFO. It drains nibbles from the FIFO's first-word-fall-through read port (dout/empty/rd_en) and packs nibble pairs into bytes, low nibble first. Bytes are presented on a valid/ready byte stream through a 2-entry output buffer. It sits between the long FIFO's read port and any byte-wide stream consumer, on the same clock.

---
 rtl/long_fifo_4bit_rd_packer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/long_fifo_4bit_rd_packer.sv
// Purpose : drains nibbles from a FWFT long-FIFO read port and packs pairs into bytes (low nibble first).
// Latency : high-nibble pop in cycle N -> m_tvalid in cycle N+1 when the 2-entry output buffer is empty.
// Backpr. : with buffer full in HI no nibble is popped; optional LONG_FIFO_RD_PACKER_TIMEOUT_EN flushes a lone low nibble.
module long_fifo_4bit_rd_packer #(
  parameter int HOLDOFF = 8,
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tpartial,
  output logic [31:0] byte_cnt
);

`ifdef LONG_FIFO_RD_PACKER_TIMEOUT_EN
  // Buffer entries carry a partial flag above the data byte.
  localparam int ENTRY_W = 9;
`else
  localparam int ENTRY_W = 8;
  // No flush path in this build, so the timeout value has no consumer.
  localparam int timeout_unused = TIMEOUT;
`endif

  typedef enum logic {ST_LO, ST_HI} state_t;

  state_t               state_q, state_d;
  logic [3:0]           hold_cnt;
  logic                 rd_en_ok;
  logic [3:0]           lo_q;
  logic [ENTRY_W-1:0]   head_q, tail_q;
  logic [1:0]           cnt_q;
  logic                 push;
  logic [ENTRY_W-1:0]   push_entry;
  logic                 pop_out;

  assign rd_en_ok = (hold_cnt == 4'(HOLDOFF));
  assign pop_out  = m_tvalid && m_tready;
  assign m_tvalid = (cnt_q != 2'd0);
  assign m_tdata  = head_q[7:0];

`ifdef LONG_FIFO_RD_PACKER_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        flush;
  assign m_tpartial = head_q[8];
`else
  assign m_tpartial = 1'b0;
`endif

  // Post-reset read lockout: saturating counter, reads allowed once it hits HOLDOFF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hold_cnt <= 4'd0;
    else if (hold_cnt != 4'(HOLDOFF))
      hold_cnt <= hold_cnt + 4'd1;
  end

  // Pop decision, next state and buffer push (normal pack or timeout flush).
  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
`ifdef LONG_FIFO_RD_PACKER_TIMEOUT_EN
    flush      = 1'b0;
    push_entry = {1'b0, fifo_dout, lo_q};
`else
    push_entry = {fifo_dout, lo_q};
`endif
    fifo_rd_en = rd_en_ok && !fifo_empty && ((state_q == ST_LO) || (cnt_q < 2'd2));
    case (state_q)
      ST_LO: begin
        if (fifo_rd_en)
          state_d = ST_HI;
      end
      ST_HI: begin
        if (fifo_rd_en) begin
          state_d = ST_LO;
          push    = 1'b1;
        end
`ifdef LONG_FIFO_RD_PACKER_TIMEOUT_EN
        // A real high nibble always wins over the flush.
        else if (fifo_empty && (tmo_cnt == 16'(TIMEOUT - 1)) && (cnt_q < 2'd2)) begin
          flush      = 1'b1;
          push       = 1'b1;
          push_entry = {1'b1, 4'h0, lo_q};
          state_d    = ST_LO;
        end
`endif
      end
      default: state_d = ST_LO;
    endcase
  end

  // State register and low-nibble capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LO;
      lo_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_LO && fifo_rd_en)
        lo_q <= fifo_dout;
    end
  end

`ifdef LONG_FIFO_RD_PACKER_TIMEOUT_EN
  // Empty-cycle counter for a held low nibble; saturates while a flush waits for space.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tmo_cnt <= 16'd0;
    else if (state_q == ST_LO || fifo_rd_en || flush)
      tmo_cnt <= 16'd0;
    else if (fifo_empty && tmo_cnt != 16'(TIMEOUT - 1))
      tmo_cnt <= tmo_cnt + 16'd1;
  end
`endif

  // Two-entry output buffer as head/tail registers; head drives the stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      case ({push, pop_out})
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= push_entry;
          else               tail_q <= push_entry;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          if (cnt_q == 2'd2) head_q <= tail_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_q <= push_entry;
          end else begin
            head_q <= tail_q;
            tail_q <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  // Handed-off byte counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      byte_cnt <= 32'd0;
    else if (pop_out)
      byte_cnt <= byte_cnt + 32'd1;
  end

endmodule
